// File: rtl/feedback_pkg.sv
// Shared definitions for the feedback receive path: FSM state encoding and
// default counter widths.
package feedback_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned WIN_W_DEF = 16;

endpackage : feedback_pkg

// File: rtl/glitch_filter.sv
// Synchronises the raw feedback level into clk, accepts a new level only after
// FILT_LEN identical synchronised samples, and emits one-cycle edge strobes.
// Ports:
//   clk, rst    - system clock, asynchronous active-high reset
//   fb_in       - raw feedback level, asynchronous to clk
//   fb_clean    - filtered level (registered)
//   rise_pulse  - one-cycle strobe on fb_clean 0->1 (registered)
//   fall_pulse  - one-cycle strobe on fb_clean 1->0 (registered)
module glitch_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic fb_in,
    output logic fb_clean,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FILT_LEN-1:0]    shr_q, shr_d;
    logic                   fb_clean_q, fb_clean_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s_out;
    logic                   all_one;
    logic                   all_zero;

    assign s_out    = sync_q[SYNC_STAGES-1];
    assign all_one  = &shr_q;
    assign all_zero = ~|shr_q;

    // Shift in at bit 0; the truncating cast drops the oldest sample.
    assign sync_d = SYNC_STAGES'({sync_q, fb_in});
    assign shr_d  = FILT_LEN'({shr_q, s_out});

    // Level acceptance and strobe generation
    always_comb begin
        fb_clean_d = fb_clean_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        if (all_one && !fb_clean_q) begin
            fb_clean_d = 1'b1;
            rise_d     = 1'b1;
        end else if (all_zero && fb_clean_q) begin
            fb_clean_d = 1'b0;
            fall_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            shr_q      <= '0;
            fb_clean_q <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            shr_q      <= shr_d;
            fb_clean_q <= fb_clean_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
        end
    end

    assign fb_clean   = fb_clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule : glitch_filter

// File: rtl/feedback_rx.sv
// Feedback receiver: cleans the asynchronous feedback level and counts its
// rising edges over a programmable window of clk cycles.
// Ports:
//   clk, rst     - system clock, asynchronous active-high reset
//   fb_in        - raw feedback level
//   start        - request a window (accepted in IDLE/DONE only)
//   win_len      - window length in cycles, sampled on accepted start
//   fb_clean     - filtered feedback level
//   rise_pulse   - fb_clean rising-edge strobe
//   fall_pulse   - fb_clean falling-edge strobe
//   busy         - window running
//   count        - rising edges in last completed window
//   count_valid  - one-cycle strobe on count update
//   ovf          - edge count saturated in last window
module feedback_rx
    import feedback_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 3,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned WIN_W       = WIN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fb_in,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    output logic             fb_clean,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             ovf
);

    logic [1:0]       state_q, state_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] acc_q, acc_d, acc_inc;
    logic             sat_q, sat_d, sat_inc;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             count_valid_q, count_valid_d;
    logic             ovf_q, ovf_d;
    logic             last_c;

    glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_filt (
        .clk        (clk),
        .rst        (rst),
        .fb_in      (fb_in),
        .fb_clean   (fb_clean),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    // win_cnt of 1 marks the final counted cycle; 0 only occurs for win_len==0.
    assign last_c = (win_cnt_q <= WIN_W'(1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = COUNT;
            COUNT:      if (last_c) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Saturating accumulator step for the current cycle
    always_comb begin
        acc_inc = acc_q;
        sat_inc = sat_q;
        if (rise_pulse) begin
            if (&acc_q) sat_inc = 1'b1;
            else        acc_inc = acc_q + CNT_W'(1);
        end
    end

    // Output / datapath next values
    always_comb begin
        win_cnt_d     = win_cnt_q;
        acc_d         = acc_q;
        sat_d         = sat_q;
        busy_d        = busy_q;
        count_d       = count_q;
        ovf_d         = ovf_q;
        count_valid_d = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    win_cnt_d = win_len;
                    acc_d     = '0;
                    sat_d     = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            COUNT: begin
                acc_d     = acc_inc;
                sat_d     = sat_inc;
                win_cnt_d = win_cnt_q - WIN_W'(1);
                if (last_c) begin
                    busy_d        = 1'b0;
                    count_valid_d = 1'b1;
                    // A zero-length window reports nothing even if an edge arrived.
                    if (win_cnt_q == '0) begin
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        count_d = acc_inc;
                        ovf_d   = sat_inc;
                    end
                end
            end
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt_q     <= '0;
            acc_q         <= '0;
            sat_q         <= 1'b0;
            busy_q        <= 1'b0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            win_cnt_q     <= win_cnt_d;
            acc_q         <= acc_d;
            sat_q         <= sat_d;
            busy_q        <= busy_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
            ovf_q         <= ovf_d;
        end
    end

    assign busy        = busy_q;
    assign count       = count_q;
    assign count_valid = count_valid_q;
    assign ovf         = ovf_q;

endmodule : feedback_rx
